sine_wave_analyzer: RTL
=======================

# sine_wave_analyzer

Receive-side counterpart of the sine sample generator: consumes a stream of signed 16-bit sine samples and measures the waveform period, in samples, plus its peak, trough and amplitude. It sits downstream of any sample source (generator, loopback or capture path) and reports per-cycle measurements, a lock indication and an error pulse for malformed waveforms. Used for self-check of generated tones and for characterising received tones.

## Interface
- DATA_W, 16, sample width (signed two's complement)
- CNT_W, 16, period counter width
- MIN_PERIOD, 4, shortest period (samples) accepted as valid
- MAX_PERIOD, 1024, longest period accepted; must be < 2^CNT_W - 1
- Reset is synchronous and active-low.
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- sample_in  in  DATA_W  signed sample
- sample_valid  in  1  sample_in is consumed this cycle when high
- period_out  out  CNT_W  last valid period in samples
- peak_out  out  DATA_W  signed max of last valid period
- trough_out  out  DATA_W  signed min of last valid period
- amplitude_out  out  DATA_W  unsigned (peak - trough) >> 1
- dc_offset_out  out  DATA_W  signed (peak + trough) >>> 1; see Configuration
- meas_valid  out  1  one-cycle pulse when the outputs above update
- locked  out  1  stable-period indication
- err  out  1  one-cycle pulse on timeout or short period

## Operation
- Rising zero crossing (ZC): sample_valid high, prev_neg = 1, sample_in >= 0. prev_neg updates to (sample_in < 0) on every accepted sample; reset value 0, so the first sample after reset is never a ZC.
- States: SEARCH (reset state), MEASURE.
- SEARCH: ignore samples until ZC; on ZC go MEASURE, count = 1, run_peak = run_trough = sample_in.
- MEASURE, accepted non-ZC sample: if count == MAX_PERIOD then timeout: err pulse, locked = 0, go SEARCH; else count += 1, run_peak = max, run_trough = min (signed compare).
- MEASURE, ZC: candidate period = count.
  - MIN_PERIOD <= count <= MAX_PERIOD: register period_out, peak_out, trough_out, amplitude_out, dc_offset_out from the run values; meas_valid pulse.
  - count < MIN_PERIOD: err pulse, locked = 0, outputs hold.
  - In all cases restart: count = 1, run_peak = run_trough = sample_in, stay MEASURE.
- locked: set on a valid measurement whose period equals the previous valid period; cleared on a valid measurement with a different period, short period, timeout or reset.
- Arithmetic: peak - trough and peak + trough computed at DATA_W+1 bits, then shifted right by 1 and truncated to DATA_W; no overflow possible.
- sample_valid low: no state, counter or prev_neg change; pulses stay low.

## Timing
- All outputs registered. Reset values: period_out, peak_out, trough_out, amplitude_out, dc_offset_out = 0; meas_valid, locked, err = 0; state SEARCH.
- meas_valid / err assert the cycle after the clock edge that accepted the ZC (or timeout) sample; held exactly one cycle.
- locked changes in the same cycle meas_valid/err asserts.
- Measurement outputs hold between meas_valid pulses.
- rst_n low overrides any simultaneous sample; mid-period reset discards the partial measurement.
- Back-to-back valid samples every cycle supported; no backpressure.

## Configuration
- SINE_ANALYZER_DC_OFFSET_EN defined: dc_offset_out computed and registered as above.
- Not defined: dc_offset_out tied to 0, offset adder removed.

## Test plan
- Reset then 29-sample table 0,16,31,45,58,67,74,77,77,74,67,58,45,31,16,0,-16,-31,-45,-58,-67,-74,-77,-77,-74,-67,-58,-45,-31 repeated 4 times, sample_valid high -> first meas_valid after 2nd crossing: period 29, peak 77, trough -77, amplitude 77, dc_offset 0 (macro on); locked high from 2nd meas_valid.
- Same stream with sample_valid toggling 1/0 -> identical measurements; meas_valid spacing doubles.
- Add +100 to every sample -> no crossing, count reaches MAX_PERIOD -> err pulse, locked 0, state SEARCH, outputs hold prior values.
- Sequence -1,1,-1,1 (period 2) after lock -> err pulse per crossing, locked 0, no meas_valid.
- Lock on 29-sample tone, then switch to 30-sample tone -> one meas_valid with period 30, locked 0, next meas_valid locked 1.
- Assert rst_n low mid-period for 1 cycle -> all outputs 0 next cycle; resume stream -> first meas_valid after two crossings.

Source files
------------

// File: rtl/sine_wave_analyzer.sv
// sine_wave_analyzer: measures period, peak, trough, amplitude of a signed sample stream
// Ports: clk, rst_n (sync active-low); sample_in/sample_valid stream in;
//   period_out, peak_out, trough_out, amplitude_out, dc_offset_out registered results;
//   meas_valid/err one-cycle pulses, locked stable-period flag.
// Optional: define SINE_ANALYZER_DC_OFFSET_EN to compute dc_offset_out (tied to 0 otherwise).
module sine_wave_analyzer #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 4,
  parameter int MAX_PERIOD = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  output logic        [CNT_W-1:0]  period_out,
  output logic signed [DATA_W-1:0] peak_out,
  output logic signed [DATA_W-1:0] trough_out,
  output logic        [DATA_W-1:0] amplitude_out,
  output logic signed [DATA_W-1:0] dc_offset_out,
  output logic                     meas_valid,
  output logic                     locked,
  output logic                     err
);
  typedef enum logic {SEARCH, MEASURE} state_t;
  state_t state, state_n;
  logic prev_neg, zc, at_zc, good, short_p, tmo;
  logic [CNT_W-1:0] count;
  logic signed [DATA_W-1:0] run_peak, run_trough;
  logic [DATA_W:0] diff;
  assign diff = {run_peak[DATA_W-1], run_peak} - {run_trough[DATA_W-1], run_trough};
  always_comb begin
    zc      = sample_valid && prev_neg && !sample_in[DATA_W-1];
    at_zc   = state == MEASURE && zc;
    good    = at_zc && count >= CNT_W'(MIN_PERIOD) && count <= CNT_W'(MAX_PERIOD);
    short_p = at_zc && count < CNT_W'(MIN_PERIOD);
    tmo     = state == MEASURE && sample_valid && !zc && count == CNT_W'(MAX_PERIOD);
    state_n = state == SEARCH ? (zc ? MEASURE : SEARCH) : (tmo ? SEARCH : MEASURE);
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= SEARCH;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_neg      <= 1'b0;
      count         <= '0;
      run_peak      <= '0;
      run_trough    <= '0;
      period_out    <= '0;
      peak_out      <= '0;
      trough_out    <= '0;
      amplitude_out <= '0;
      meas_valid    <= 1'b0;
      locked        <= 1'b0;
      err           <= 1'b0;
    end else begin
      meas_valid <= good;
      err        <= short_p || tmo;
      if (sample_valid) prev_neg <= sample_in[DATA_W-1];
      // a crossing always opens a new period, whether it arms SEARCH or closes one in MEASURE
      if (zc) begin
        count      <= CNT_W'(1);
        run_peak   <= sample_in;
        run_trough <= sample_in;
      end else if (sample_valid && state == MEASURE && !tmo) begin
        count      <= count + CNT_W'(1);
        run_peak   <= sample_in > run_peak ? sample_in : run_peak;
        run_trough <= sample_in < run_trough ? sample_in : run_trough;
      end
      if (good) begin
        period_out    <= count;
        peak_out      <= run_peak;
        trough_out    <= run_trough;
        amplitude_out <= DATA_W'(diff >> 1);
        locked        <= count == period_out;
      end else if (short_p || tmo) locked <= 1'b0;
    end
  end
`ifdef SINE_ANALYZER_DC_OFFSET_EN
  logic signed [DATA_W:0] sum;
  assign sum = {run_peak[DATA_W-1], run_peak} + {run_trough[DATA_W-1], run_trough};
  always_ff @(posedge clk)
    if (!rst_n) dc_offset_out <= '0;
    else if (good) dc_offset_out <= DATA_W'(sum >>> 1);
`else
  assign dc_offset_out = '0;
`endif
endmodule
